// File: rtl/mips_lite_core.sv
// mips_lite_core: single-cycle MIPS-subset core with run/halt control.
// Programs are written through the imem load port while IDLE or HALT, execution
// starts on a START level, and bytes move through ready/valid IN/OUT channels.
// Ports:
//   CLK, RST (sync, active-high), START (level, IDLE->RUN)
//   imem_we/imem_waddr/imem_wdata : instruction load port (IDLE/HALT only)
//   in_valid/in_data/in_ready     : IN channel (in_ready combinational)
//   out_valid/out_data/out_ready  : OUT channel (registered)
//   dbg_raddr/dbg_rdata           : combinational register peek
//   halted, err (sticky fault), pc (current word index)
module mips_lite_core #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 512,
    parameter int unsigned IO_W       = 8,
    parameter logic [31:0] FP_INIT    = 32'h40
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          in_valid,
    input  logic [IO_W-1:0]               in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [IO_W-1:0]               out_data,
    input  logic                          out_ready,
    input  logic [4:0]                    dbg_raddr,
    output logic [31:0]                   dbg_rdata,
    output logic                          halted,
    output logic                          err,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc
);
    localparam int unsigned PW  = $clog2(IMEM_DEPTH);
    // One extra bit so running off the end of imem is visible as pc >= IMEM_DEPTH.
    localparam int unsigned PCW = PW + 1;
    localparam int unsigned DW  = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_R    = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111, OP_IN   = 6'b011010, OP_OUT  = 6'b011011;
    localparam logic [5:0] OP_LW   = 6'b100011, OP_SW   = 6'b101011, OP_HALT = 6'b111111;
    localparam logic [5:0] FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_JR   = 6'b001000;
    localparam logic [5:0] FN_JALR = 6'b001001, FN_ADD  = 6'b100000, FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100, FN_OR   = 6'b100101, FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_OUT, S_HALT} state_t;

    state_t           state;
    logic [PCW-1:0]   pc_q;
    logic [31:0]      rf   [32];
    logic [31:0]      imem [IMEM_DEPTH];
    logic [31:0]      dmem [DMEM_DEPTH];

    logic [31:0]      instr, imm_s, imm_z, rs_val, rt_val, wr_data, dm_addr, dm_rdata;
    logic [PCW-1:0]   pc_inc, pc_next;
    logic [4:0]       wr_idx;
    logic             wr_en, dm_we, dm_bad, dm_fault, go_halt, go_out, fetch_fault, exec;

    // Out-of-range jump targets saturate to IMEM_DEPTH so the next fetch faults.
    function automatic logic [PCW-1:0] clamp_pc(input logic [31:0] t);
        return (t >= 32'(IMEM_DEPTH)) ? PCW'(IMEM_DEPTH) : PCW'(t);
    endfunction

    assign pc        = pc_q[PW-1:0];
    assign halted    = (state == S_HALT);
    assign dbg_rdata = rf[dbg_raddr];

    // Fetch, decode and execute for the instruction at pc_q.
    always_comb begin
        instr       = imem[pc_q[PW-1:0]];
        imm_s       = {{16{instr[15]}}, instr[15:0]};
        imm_z       = {16'd0, instr[15:0]};
        rs_val      = rf[instr[25:21]];
        rt_val      = rf[instr[20:16]];
        pc_inc      = pc_q + PCW'(1);
        fetch_fault = (pc_q >= PCW'(IMEM_DEPTH));
        exec        = (state == S_RUN) && !fetch_fault;
        dm_addr     = rs_val + imm_s;
        dm_bad      = (dm_addr >= 32'(DMEM_DEPTH));
        dm_rdata    = dm_bad ? 32'd0 : dmem[dm_addr[DW-1:0]];

        wr_en    = 1'b0;
        wr_idx   = instr[20:16];
        wr_data  = 32'd0;
        pc_next  = pc_inc;
        dm_we    = 1'b0;
        dm_fault = 1'b0;
        go_halt  = 1'b0;
        go_out   = 1'b0;
        in_ready = 1'b0;

        case (instr[31:26])
            OP_R: begin
                wr_en  = 1'b1;
                wr_idx = instr[15:11];
                case (instr[5:0])
                    FN_ADD:  wr_data = rs_val + rt_val;
                    FN_SUB:  wr_data = rs_val - rt_val;
                    FN_AND:  wr_data = rs_val & rt_val;
                    FN_OR:   wr_data = rs_val | rt_val;
                    FN_NOR:  wr_data = ~(rs_val | rt_val);
                    FN_SLT:  wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL:  wr_data = rt_val << instr[10:6];
                    FN_SRL:  wr_data = rt_val >> instr[10:6];
                    FN_JR: begin
                        wr_en   = 1'b0;
                        pc_next = clamp_pc(rs_val);
                    end
                    FN_JALR: begin
                        wr_data = 32'(pc_inc);
                        pc_next = clamp_pc(rs_val);
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_ADDI: begin wr_en = 1'b1; wr_data = rs_val + imm_s; end
            OP_ANDI: begin wr_en = 1'b1; wr_data = rs_val & imm_z; end
            OP_ORI:  begin wr_en = 1'b1; wr_data = rs_val | imm_z; end
            OP_SLTI: begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(imm_s)}; end
            OP_LUI:  begin wr_en = 1'b1; wr_data = {instr[15:0], 16'd0}; end
            OP_LW: begin
                wr_en    = 1'b1;
                wr_data  = dm_rdata;
                dm_fault = dm_bad;
            end
            OP_SW: begin
                dm_we    = !dm_bad;
                dm_fault = dm_bad;
            end
            OP_BEQ: if (rs_val == rt_val) pc_next = clamp_pc(32'(pc_inc) + imm_s);
            OP_BNE: if (rs_val != rt_val) pc_next = clamp_pc(32'(pc_inc) + imm_s);
            OP_J:   pc_next = PCW'(instr[PW-1:0]);
            OP_JAL: begin
                pc_next = PCW'(instr[PW-1:0]);
                wr_en   = 1'b1;
                wr_idx  = 5'd31;
                wr_data = 32'(pc_inc);
            end
            OP_IN: begin
                in_ready = exec;
                // No data yet: hold pc so the IN re-issues next cycle.
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_data = 32'(in_data);
                end else begin
                    pc_next = pc_q;
                end
            end
            OP_OUT:  go_out  = 1'b1;
            OP_HALT: go_halt = 1'b1;
            default: ;
        endcase
    end

    // Run/halt state machine with pc, OUT channel and sticky fault flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            pc_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (START) begin
                    state <= S_RUN;
                    pc_q  <= '0;
                end
                S_RUN: begin
                    if (fetch_fault) begin
                        err   <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        if (dm_fault) err <= 1'b1;
                        if (go_halt) begin
                            state <= S_HALT;
                        end else if (go_out) begin
                            out_valid <= 1'b1;
                            out_data  <= rt_val[IO_W-1:0];
                            state     <= S_WAIT_OUT;
                        end else begin
                            pc_q <= pc_next;
                        end
                    end
                end
                S_WAIT_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    pc_q      <= pc_inc;
                    state     <= S_RUN;
                end
                S_HALT: if (!START) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register file; r0 is never written so it always reads zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 31) ? FP_INIT : 32'd0;
        end else if (exec && wr_en && (wr_idx != 5'd0)) begin
            rf[wr_idx] <= wr_data;
        end
    end

    // Instruction and data memories; contents are not reset.
    always_ff @(posedge CLK) begin
        if (!RST && imem_we && (state == S_IDLE || state == S_HALT)) imem[imem_waddr] <= imem_wdata;
        if (!RST && exec && dm_we) dmem[dm_addr[DW-1:0]] <= rt_val;
    end
endmodule

// File: tb/tb_mips_lite_core.sv
// Self-checking bench for mips_lite_core: per-scenario tasks with queue-based
// expectations for OUT bytes, register results and pc traces.
module tb_mips_lite_core;
    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned DMEM_DEPTH = 512;
    localparam int unsigned IO_W       = 8;
    localparam logic [31:0] FP_INIT    = 32'h40;
    localparam int unsigned PW         = $clog2(IMEM_DEPTH);

    localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] LUI  = 6'b001111, LW   = 6'b100011, SW   = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101, J    = 6'b000010, JAL  = 6'b000011, IN  = 6'b011010;
    localparam logic [5:0] OUTI = 6'b011011, HLT  = 6'b111111;

    logic            CLK = 1'b0;
    logic            RST, START, imem_we, in_valid, in_ready, out_valid, out_ready, halted, err;
    logic [PW-1:0]   imem_waddr, pc;
    logic [31:0]     imem_wdata, dbg_rdata;
    logic [IO_W-1:0] in_data, out_data;
    logic [4:0]      dbg_raddr;

    int checks = 0;
    int errors = 0;

    logic [IO_W-1:0] out_exp[$];
    logic [4:0]      reg_idx_q[$];
    logic [31:0]     reg_val_q[$];
    int              pc_exp[$];

    mips_lite_core #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .IO_W(IO_W), .FP_INIT(FP_INIT)) dut (
        .CLK(CLK), .RST(RST), .START(START), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata), .halted(halted), .err(err), .pc(pc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic load(input int a, input logic [31:0] w);
        imem_we    = 1'b1;
        imem_waddr = PW'(a);
        imem_wdata = w;
        step();
        imem_we    = 1'b0;
    endtask

    task automatic expect_reg(input logic [4:0] r, input logic [31:0] v);
        reg_idx_q.push_back(r);
        reg_val_q.push_back(v);
    endtask

    task automatic run_to_halt(input int max, output int n);
        n = 0;
        while (!halted && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b want=0", halted); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc got=%0d want=0", pc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        dbg_raddr = 5'd31; #1;
        checks++; if (dbg_rdata !== FP_INIT) begin errors++; $display("FAIL reset_r31 got=%h want=%h", dbg_rdata, FP_INIT); end
        dbg_raddr = 5'd30; #1;
        checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_r30 got=%h want=0", dbg_rdata); end
    endtask

    // ADDI / OUT / HALT: one byte out, HALT on the fifth edge after START.
    task automatic test_basic();
        int n;
        int seen;
        load(0, enc_i(ADDI, 5'd0, 5'd1, 16'd3));
        load(1, enc_i(OUTI, 5'd0, 5'd1, 16'd0));
        load(2, enc_i(HLT, 5'd0, 5'd0, 16'd0));
        out_exp.push_back(8'h03);
        out_ready = 1'b1;
        START = 1'b1;
        n = 0;
        seen = 0;
        while (!halted && n < 20) begin
            step();
            n++;
            if (out_valid && out_ready) begin
                seen++;
                if (out_exp.size() == 0) begin
                    checks++; errors++; $display("FAIL basic_extra_out got=%h", out_data);
                end else begin
                    logic [IO_W-1:0] e;
                    e = out_exp.pop_front();
                    checks++; if (out_data !== e) begin errors++; $display("FAIL basic_out_data got=%h want=%h", out_data, e); end
                end
            end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halt_timeout halted=%b", halted); end
        checks++; if (n != 5) begin errors++; $display("FAIL basic_cycles got=%0d want=5", n); end
        checks++; if (seen != 1) begin errors++; $display("FAIL basic_out_count got=%0d want=1", seen); end
        checks++; if (pc !== PW'(2)) begin errors++; $display("FAIL basic_pc got=%0d want=2", pc); end
        START = 1'b0;
        step();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL basic_halt_to_idle halted=%b want=0", halted); end
    endtask

    task automatic test_alu();
        int n;
        do_reset();
        load(0,  enc_i(ADDI, 5'd0, 5'd1, 16'd5));            expect_reg(1, 32'd5);
        load(1,  enc_i(ADDI, 5'd0, 5'd2, 16'd7));            expect_reg(2, 32'd7);
        load(2,  enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'b100010));  expect_reg(3, 32'hFFFF_FFFE);
        load(3,  enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'b101010));  expect_reg(4, 32'd1);
        load(4,  enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'b101010));  expect_reg(5, 32'd0);
        load(5,  enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'b100100));  expect_reg(6, 32'd5);
        load(6,  enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'b100101));  expect_reg(7, 32'd7);
        load(7,  enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'b100111));  expect_reg(8, 32'hFFFF_FFF8);
        load(8,  enc_r(5'd0, 5'd2, 5'd9, 5'd4, 6'b000000));  expect_reg(9, 32'h70);
        load(9,  enc_i(LUI, 5'd0, 5'd11, 16'h8000));         expect_reg(11, 32'h8000_0000);
        load(10, enc_r(5'd0, 5'd11, 5'd12, 5'd31, 6'b000010)); expect_reg(12, 32'd1);
        load(11, enc_i(ORI, 5'd0, 5'd13, 16'hFFFF));         expect_reg(13, 32'h0000_FFFF);
        load(12, enc_i(ADDI, 5'd0, 5'd15, 16'hFFFF));        expect_reg(15, 32'hFFFF_FFFF);
        load(13, enc_i(SLTI, 5'd15, 5'd16, 16'd0));          expect_reg(16, 32'd1);
        load(14, enc_i(ANDI, 5'd15, 5'd17, 16'h8001));       expect_reg(17, 32'h8001);
        load(15, enc_r(5'd1, 5'd2, 5'd18, 5'd0, 6'b100000)); expect_reg(18, 32'd12);
        load(16, enc_i(ADDI, 5'd0, 5'd0, 16'd9));            expect_reg(0, 32'd0);
        load(17, enc_i(SW, 5'd0, 5'd1, 16'd20));
        load(18, enc_i(LW, 5'd0, 5'd19, 16'd20));            expect_reg(19, 32'd5);
        load(19, enc_i(BEQ, 5'd1, 5'd2, 16'd5));
        load(20, enc_i(ADDI, 5'd0, 5'd21, 16'd23));          expect_reg(21, 32'd23);
        load(21, enc_r(5'd21, 5'd0, 5'd22, 5'd0, 6'b001001)); expect_reg(22, 32'd22);
        load(22, enc_i(ADDI, 5'd0, 5'd23, 16'd1));           expect_reg(23, 32'd0);
        load(23, enc_i(HLT, 5'd0, 5'd0, 16'd0));
        START = 1'b1;
        run_to_halt(60, n);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL alu_halt_timeout halted=%b", halted); end
        checks++; if (pc !== PW'(23)) begin errors++; $display("FAIL alu_final_pc got=%0d want=23", pc); end
        while (reg_idx_q.size() > 0) begin
            logic [4:0]  r;
            logic [31:0] v;
            r = reg_idx_q.pop_front();
            v = reg_val_q.pop_front();
            dbg_raddr = r; #1;
            checks++; if (dbg_rdata !== v) begin errors++; $display("FAIL alu_reg r%0d got=%h want=%h", r, dbg_rdata, v); end
        end
        START = 1'b0;
        step();
    endtask

    // IN stall for 5 cycles, then OUT held 3 cycles by backpressure.
    task automatic test_in_out();
        int n;
        do_reset();
        load(0, enc_i(IN, 5'd0, 5'd2, 16'd0));
        load(1, enc_i(OUTI, 5'd0, 5'd2, 16'd0));
        load(2, enc_i(HLT, 5'd0, 5'd0, 16'd0));
        out_exp.push_back(8'hA5);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        START = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_stall_ready cyc=%0d got=%b want=1", i, in_ready); end
            checks++; if (pc !== PW'(0)) begin errors++; $display("FAIL in_stall_pc cyc=%0d got=%0d want=0", i, pc); end
            // A load attempt while running must be ignored.
            imem_we = (i == 2); imem_waddr = PW'(1); imem_wdata = enc_i(HLT, 5'd0, 5'd0, 16'd0);
            step();
            imem_we = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = 8'hA5;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        checks++; if (pc !== PW'(1)) begin errors++; $display("FAIL in_pc_after got=%0d want=1", pc); end
        dbg_raddr = 5'd2; #1;
        checks++; if (dbg_rdata !== 32'hA5) begin errors++; $display("FAIL in_r2 got=%h want=000000a5", dbg_rdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_on_out got=%b want=0", in_ready); end
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL out_hold cyc=%0d valid=%b data=%h want 1/a5", i, out_valid, out_data); end
            checks++; if (pc !== PW'(1)) begin errors++; $display("FAIL out_hold_pc cyc=%0d got=%0d want=1", i, pc); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL out_in_ready cyc=%0d got=%b want=0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        if (out_exp.size() == 0) begin
            checks++; errors++; $display("FAIL out_unexpected got=%h", out_data);
        end else begin
            logic [IO_W-1:0] e;
            e = out_exp.pop_front();
            checks++; if (!out_valid || out_data !== e) begin errors++; $display("FAIL out_handshake valid=%b data=%h want=%h", out_valid, out_data, e); end
        end
        step();
        checks++; if (out_valid !== 1'b0 || pc !== PW'(2)) begin errors++; $display("FAIL out_after valid=%b pc=%0d want 0/2", out_valid, pc); end
        run_to_halt(10, n);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL inout_halt halted=%b want=1", halted); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready got=%b want=0", in_ready); end
        START = 1'b0;
        step();
    endtask

    task automatic test_jumps();
        do_reset();
        load(0, enc_i(ADDI, 5'd0, 5'd1, 16'd1));
        load(1, enc_j(JAL, 26'd5));
        load(2, enc_j(J, 26'd4));
        load(3, enc_i(HLT, 5'd0, 5'd0, 16'd0));
        load(4, enc_i(BNE, 5'd1, 5'd0, 16'hFFFE));
        load(5, enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'b001000));
        pc_exp = '{0, 1, 5, 2, 4, 3};
        START = 1'b1;
        while (pc_exp.size() > 0) begin
            int e;
            step();
            e = pc_exp.pop_front();
            checks++; if (pc !== PW'(e)) begin errors++; $display("FAIL jump_pc got=%0d want=%0d", pc, e); end
        end
        dbg_raddr = 5'd31; #1;
        checks++; if (dbg_rdata !== 32'd2) begin errors++; $display("FAIL jal_r31 got=%h want=2", dbg_rdata); end
        step();
        checks++; if (halted !== 1'b1 || pc !== PW'(3)) begin errors++; $display("FAIL jump_halt halted=%b pc=%0d want 1/3", halted, pc); end
        START = 1'b0;
        step();
    endtask

    task automatic test_faults();
        int n;
        do_reset();
        load(0, enc_i(ADDI, 5'd0, 5'd3, 16'h11));
        load(1, enc_i(SW, 5'd0, 5'd3, 16'd0));
        load(2, enc_i(ADDI, 5'd0, 5'd1, 16'(DMEM_DEPTH)));
        load(3, enc_i(ADDI, 5'd0, 5'd2, 16'h77));
        load(4, enc_i(SW, 5'd1, 5'd2, 16'd0));
        load(5, enc_i(LW, 5'd0, 5'd4, 16'd0));
        load(6, enc_i(ADDI, 5'd0, 5'd5, 16'd9));
        load(7, enc_i(LW, 5'd1, 5'd5, 16'd0));
        load(8, enc_j(J, 26'(IMEM_DEPTH - 1)));
        load(IMEM_DEPTH - 1, 32'd0);
        START = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL fault_err_early got=%b want=0", err); end
        step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_sw_err got=%b want=1", err); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fault_sw_continues halted=%b want=0", halted); end
        run_to_halt(20, n);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL fault_fetch_halt halted=%b want=1", halted); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL fault_err_sticky got=%b want=1", err); end
        dbg_raddr = 5'd4; #1;
        checks++; if (dbg_rdata !== 32'h11) begin errors++; $display("FAIL fault_mem_unchanged got=%h want=11", dbg_rdata); end
        dbg_raddr = 5'd5; #1;
        checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL fault_lw_zero got=%h want=0", dbg_rdata); end
    endtask

    // Reset in the middle of an OUT handshake; err from the previous test is still set.
    task automatic test_reset_wait_out();
        load(0, enc_i(OUTI, 5'd0, 5'd31, 16'd0));
        load(1, enc_i(HLT, 5'd0, 5'd0, 16'd0));
        out_ready = 1'b0;
        START = 1'b0;
        step();
        START = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== FP_INIT[IO_W-1:0]) begin errors++; $display("FAIL rwo_out valid=%b data=%h want 1/40", out_valid, out_data); end
        START = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL rwo_start_ignored valid=%b halted=%b want 1/0", out_valid, halted); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL rwo_err_before got=%b want=1", err); end
        RST = 1'b1;
        step();
        RST = 1'b0;
        checks++; if (out_valid !== 1'b0 || err !== 1'b0 || pc !== '0) begin errors++; $display("FAIL rwo_reset valid=%b err=%b pc=%0d want 0/0/0", out_valid, err, pc); end
        step();
        checks++; if (in_ready !== 1'b0 || halted !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rwo_idle in_ready=%b halted=%b valid=%b", in_ready, halted, out_valid); end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; dbg_raddr = '0;
        test_reset();
        test_basic();
        test_alu();
        test_in_out();
        test_jumps();
        test_faults();
        test_reset_wait_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
